// File: rtl/fft_r22sdf_pkg.sv
// Shared types and constant helpers for the R2^2SDF FFT sequencer: FSM states,
// twiddle digit map, stage delay and bit-reversal helpers.
package fft_r22sdf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Radix-2^2 digit map {0,2,1,3}, entry i at bits [2i +: 2]
  localparam logic [7:0] DIGIT_MAP = {2'd3, 2'd1, 2'd2, 2'd0};

  // Cumulative latency up to and including stage pair s
  function automatic int stage_delay(input int s, input int n, input int stage_reg);
    int d;
    int q;
    d = 0;
    q = n;
    for (int j = 0; j <= s; j++) begin
      q = q / 4;
      d = d + 3 * q;
    end
    return d + stage_reg * (s + 1);
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      r[w-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_r22sdf_tw_addr.sv
// Twiddle ROM address for one multiplier stage: splits the stage-local index into
// (n1, n2), applies the digit map and scales the product to the full-length ROM.
module fft_r22sdf_tw_addr
  import fft_r22sdf_pkg::*;
#(
  parameter int NLOG2 = 10,
  parameter int STAGE = 0
) (
  input  logic [NLOG2-2*STAGE-1:0] k_i,
  output logic [NLOG2-1:0]         addr_o
);

  localparam int M = NLOG2 - 2 * STAGE;

  logic [1:0]       n1;
  logic [M-3:0]     n2;
  logic [1:0]       m;
  logic [M-1:0]     prod;
  logic [NLOG2-1:0] prod_ext;

  always_comb begin
    n1       = k_i[M-1 -: 2];
    n2       = k_i[M-3:0];
    m        = DIGIT_MAP[{n1, 1'b0} +: 2];
    prod     = M'(n2) * M'(m);
    prod_ext = NLOG2'(prod);
    addr_o   = prod_ext << (2 * STAGE);
  end

endmodule

// File: rtl/fft_r22sdf_ctrl.sv
// Sequencer for the single-path R2^2SDF FFT: clock enable, sample counters, twiddle
// addresses and output valid/last. FFT_R22SDF_CTRL_BITREV_EN selects natural-order out_idx_o.
module fft_r22sdf_ctrl
  import fft_r22sdf_pkg::*;
#(
  parameter int FFT_N     = 1024,
  parameter int NLOG2     = 10,
  parameter int STAGE_REG = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_n,
  input  logic                           en_i,
  input  logic                           valid_i,
  output logic                           ce_o,
  output logic [NLOG2-1:0]               ctr_o,
  output logic [(NLOG2/2-1)*NLOG2-1:0]   tw_addr_o,
  output logic                           out_valid_o,
  output logic [NLOG2-1:0]               out_idx_o,
  output logic                           out_last_o,
  output logic                           busy_o
);

  localparam int NUM_TW       = NLOG2 / 2 - 1;
  localparam int PIPE_LATENCY = stage_delay(NUM_TW, FFT_N, STAGE_REG);
  localparam int FW           = $clog2(PIPE_LATENCY + 1);
  localparam logic [FW-1:0]    FILL_LAST = FW'(PIPE_LATENCY - 1);
  localparam logic [FW-1:0]    FILL_FULL = FW'(PIPE_LATENCY);
  localparam logic [NLOG2-1:0] LAT_MOD   = NLOG2'(PIPE_LATENCY % FFT_N);
  localparam logic [NLOG2-1:0] CTR_LAST  = NLOG2'(FFT_N - 1);

  state_e                     state_q, state_d;
  logic [NLOG2-1:0]           in_ctr_q, in_ctr_d;
  logic [FW-1:0]              fill_ctr_q, fill_ctr_d;
  logic [FW-1:0]              drain_ctr_q, drain_ctr_d;
  logic [NUM_TW*NLOG2-1:0]    tw_addr_q, tw_addr_d, tw_next;
  logic                       out_valid_q, out_valid_d;
  logic [NLOG2-1:0]           out_idx_q, out_idx_d;
  logic                       out_last_q, out_last_d;
  logic                       busy_q, busy_d;
  logic                       adv, boundary, full;
  logic [NLOG2-1:0]           raw_idx;

  // The start sample in IDLE advances the counters even though ce_o stays low there
  always_comb begin
    ce_o = 1'b0;
    unique case (state_q)
      IDLE:        ce_o = 1'b0;
      FILL, RUN:   ce_o = valid_i;
      DRAIN:       ce_o = 1'b1;
      default:     ce_o = 1'b0;
    endcase
    adv = ce_o | ((state_q == IDLE) & en_i & valid_i);
  end

  always_comb begin
    state_d     = state_q;
    in_ctr_d    = in_ctr_q;
    fill_ctr_d  = fill_ctr_q;
    drain_ctr_d = drain_ctr_q;
    boundary    = (in_ctr_q == CTR_LAST);
    full        = (fill_ctr_q == FILL_FULL);
    if (adv) begin
      in_ctr_d = in_ctr_q + 1'b1;
      if (!full) fill_ctr_d = fill_ctr_q + 1'b1;
    end
    unique case (state_q)
      IDLE: if (adv) state_d = FILL;
      FILL: begin
        if (adv) begin
          if (boundary && !en_i)          state_d = DRAIN;
          else if (fill_ctr_q == FILL_LAST) state_d = RUN;
        end
      end
      RUN:  if (adv && boundary && !en_i) state_d = DRAIN;
      // Last sample needs exactly PIPE_LATENCY forced enables to leave the pipe
      DRAIN: begin
        drain_ctr_d = drain_ctr_q + 1'b1;
        if (drain_ctr_q == FILL_LAST) begin
          state_d     = IDLE;
          in_ctr_d    = '0;
          fill_ctr_d  = '0;
          drain_ctr_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar s = 0; s < NUM_TW; s++) begin : g_tw
    localparam int M = NLOG2 - 2 * s;
    localparam logic [NLOG2-1:0] DS = NLOG2'(stage_delay(s, FFT_N, STAGE_REG) % FFT_N);
    logic [M-1:0] k_s;
    assign k_s = M'(in_ctr_d - DS);
    fft_r22sdf_tw_addr #(
      .NLOG2 (NLOG2),
      .STAGE (s)
    ) u_tw_addr (
      .k_i    (k_s),
      .addr_o (tw_next[s*NLOG2 +: NLOG2])
    );
  end

  always_comb begin
    raw_idx     = in_ctr_q - LAT_MOD;
    out_valid_d = adv && ((state_q == RUN) || ((state_q == DRAIN) && full));
    out_last_d  = out_valid_d && (raw_idx == CTR_LAST);
    out_idx_d   = out_idx_q;
    tw_addr_d   = tw_addr_q;
    if (adv) begin
`ifdef FFT_R22SDF_CTRL_BITREV_EN
      out_idx_d = NLOG2'(bitrev(32'(raw_idx), NLOG2));
`else
      out_idx_d = raw_idx;
`endif
      tw_addr_d = tw_next;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ctr_q    <= '0;
      fill_ctr_q  <= '0;
      drain_ctr_q <= '0;
      tw_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ctr_q    <= in_ctr_d;
      fill_ctr_q  <= fill_ctr_d;
      drain_ctr_q <= drain_ctr_d;
      tw_addr_q   <= tw_addr_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign ctr_o       = in_ctr_q;
  assign tw_addr_o   = tw_addr_q;
  assign out_valid_o = out_valid_q;
  assign out_idx_o   = out_idx_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_fft_r22sdf_ctrl.sv
// Directed bench for fft_r22sdf_ctrl at N=16 (one twiddle stage, pipeline latency 21).
module tb_fft_r22sdf_ctrl;

  localparam int N  = 16;
  localparam int NL = 4;
  localparam int SR = 3;

  logic          clk_i = 1'b0;
  logic          rst_n;
  logic          en_i;
  logic          valid_i;
  logic          ce_o;
  logic [NL-1:0] ctr_o;
  logic [NL-1:0] tw_addr_o;
  logic          out_valid_o;
  logic [NL-1:0] out_idx_o;
  logic          out_last_o;
  logic          busy_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  fft_r22sdf_ctrl #(
    .FFT_N     (N),
    .NLOG2     (NL),
    .STAGE_REG (SR)
  ) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .en_i        (en_i),
    .valid_i     (valid_i),
    .ce_o        (ce_o),
    .ctr_o       (ctr_o),
    .tw_addr_o   (tw_addr_o),
    .out_valid_o (out_valid_o),
    .out_idx_o   (out_idx_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [NL-1:0] exp_idx(input int raw);
    logic [NL-1:0] r;
    r = NL'(raw);
`ifdef FFT_R22SDF_CTRL_BITREV_EN
    return {r[0], r[1], r[2], r[3]};
`else
    return r;
`endif
  endfunction

  // Edge e is the e-th advancing clock of a run started from IDLE.
  // en_i held through edge en_last; input samples stop after edge last_e-21.
  task automatic run_frames(input int last_e, input int en_last, input int gap_e);
    int nv;
    int nl;
    int raw;
    nv = 0;
    nl = 0;
    for (int e = 0; e <= last_e; e++) begin
      en_i    = (e <= en_last);
      valid_i = (e <= last_e - 21);
      if (e == 0) begin
        #1 chk("idle_ce", ce_o, 0);
      end
      if (e == last_e - 20) begin
        #1 chk("drain_ce_forced", ce_o, 1);
      end
      cyc();
      chk("ctr", ctr_o, (e == last_e) ? 0 : (e + 1) % N);
      chk("out_valid", out_valid_o, (e >= 21) ? 1 : 0);
      if (out_valid_o) begin
        nv++;
        raw = (e - 21) % N;
        chk("out_idx", out_idx_o, exp_idx(raw));
        chk("out_last", out_last_o, (raw == N - 1) ? 1 : 0);
      end
      if (out_last_o) nl++;
      if (e == 1)  chk("tw_k3", tw_addr_o, 0);
      if (e == 3)  chk("tw_k5", tw_addr_o, 2);
      if (e == 9)  chk("tw_k11", tw_addr_o, 3);
      if (e == 12) chk("tw_k14", tw_addr_o, 6);
      if (e == gap_e) begin
        valid_i = 1'b0;
        repeat (7) begin
          #1 chk("gap_ce", ce_o, 0);
          cyc();
          chk("gap_ctr", ctr_o, 10);
          chk("gap_tw", tw_addr_o, 3);
          chk("gap_idx", out_idx_o, exp_idx(4));
          chk("gap_valid", out_valid_o, 0);
          chk("gap_busy", busy_o, 1);
        end
      end
    end
    chk("valid_total", nv, last_e - 20);
    chk("last_total", nl, (last_e - 20) / N);
    chk("busy_after_drain", busy_o, 0);
  endtask

  initial begin
    // Reset held with a pending start request
    rst_n   = 1'b0;
    en_i    = 1'b1;
    valid_i = 1'b1;
    repeat (5) cyc();
    chk("rst_ce", ce_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ctr", ctr_o, 0);
    chk("rst_tw", tw_addr_o, 0);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_idx", out_idx_o, 0);
    chk("rst_last", out_last_o, 0);
    rst_n   = 1'b1;
    en_i    = 1'b0;
    valid_i = 1'b0;
    cyc();
    chk("idle_busy", busy_o, 0);

    // One frame, boundary while still filling
    run_frames(36, 0, -1);
    en_i    = 1'b0;
    valid_i = 1'b0;
    repeat (2) cyc();

    // Three frames, en_i dropped at sample 8 of frame 3, stall in frame 2
    run_frames(68, 39, 25);
    en_i    = 1'b0;
    valid_i = 1'b0;
    repeat (2) cyc();

    // Reset in RUN then full-latency refill
    en_i    = 1'b1;
    valid_i = 1'b1;
    for (int e = 0; e <= 25; e++) cyc();
    chk("pre_rst_busy", busy_o, 1);
    chk("pre_rst_valid", out_valid_o, 1);
    rst_n = 1'b0;
    cyc();
    chk("midrst_busy", busy_o, 0);
    chk("midrst_valid", out_valid_o, 0);
    chk("midrst_ctr", ctr_o, 0);
    chk("midrst_ce", ce_o, 0);
    rst_n = 1'b1;
    for (int e = 0; e <= 22; e++) begin
      cyc();
      if (e == 20) chk("refill_e20_valid", out_valid_o, 0);
      if (e == 21) begin
        chk("refill_e21_valid", out_valid_o, 1);
        chk("refill_e21_idx", out_idx_o, exp_idx(0));
      end
      if (e == 22) chk("refill_raw1_idx", out_idx_o, exp_idx(1));
    end
    rst_n = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
